mult_div_unit: RTL and testbench

- Iterative multiply/divide unit for the MIPS datapath; next-generation companion to the combinational alu.
- Parametrised in operand width.
- Performs signed/unsigned multiply and divide over WIDTH clock cycles. Writes the results into HI/LO registers read by MFHI/MFLO.
- Uses a start/busy/done handshake toward the control unit.

---
 rtl/mult_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mult_div_unit.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative radix-2 MULT/MULTU/DIV/DIVU unit writing the HI/LO pair.
// Define MULDIV_DIVZERO_FLAG_EN to add the divz output (divide-by-zero indication).
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rd1,
    input  logic [WIDTH-1:0] rd2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
`ifdef MULDIV_DIVZERO_FLAG_EN
    output logic [WIDTH-1:0] lo,
    output logic             divz
`else
    output logic [WIDTH-1:0] lo
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               sa_q, sa_d;
    logic               sb_q, sb_d;
    logic               bz_q, bz_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               done_q, done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic               divz_q, divz_d;
`endif

    logic               signed_op;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic               rem_ge;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    // MULT and DIV (op[0]=0) work on magnitudes; signs are restored in FIX.
    assign signed_op = ~op[0];
    assign mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign rem_ge    = rem_sh >= {1'b0, b_q};
    assign prod_fix  = (sa_q ^ sb_q) ? -prod_q : prod_q;
    assign quo_fix   = (sa_q ^ sb_q) ? -quo_q : quo_q;
    assign rem_fix   = sa_q ? -rem_q : rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
            divz_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bz_q    <= bz_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
`ifdef MULDIV_DIVZERO_FLAG_EN
            divz_q  <= divz_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bz_d    = bz_q;
        a_d     = a_q;
        b_d     = b_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
`ifdef MULDIV_DIVZERO_FLAG_EN
        divz_d  = divz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    div_d   = op[1];
                    sa_d    = signed_op & rd1[WIDTH-1];
                    sb_d    = signed_op & rd2[WIDTH-1];
                    bz_d    = (rd2 == '0);
                    a_d     = (signed_op & rd1[WIDTH-1]) ? -rd1 : rd1;
                    b_d     = (signed_op & rd2[WIDTH-1]) ? -rd2 : rd2;
                    // Both datapaths are seeded; FIX picks the one matching the op.
                    prod_d  = {{WIDTH{1'b0}}, ((signed_op & rd2[WIDTH-1]) ? -rd2 : rd2)};
                    quo_d   = (signed_op & rd1[WIDTH-1]) ? -rd1 : rd1;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = CALC;
`ifdef MULDIV_DIVZERO_FLAG_EN
                    divz_d  = 1'b0;
`endif
                end
            end
            CALC: begin
                prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                rem_d  = rem_ge ? WIDTH'(rem_sh - {1'b0, b_q}) : rem_sh[WIDTH-1:0];
                quo_d  = {quo_q[WIDTH-2:0], rem_ge};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (div_q) begin
                    // With a zero divisor every trial subtract succeeds, so the
                    // remainder path reproduces the dividend; only lo is forced.
                    hi_d = rem_fix;
                    lo_d = bz_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef MULDIV_DIVZERO_FLAG_EN
                divz_d  = div_q & bz_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
`ifdef MULDIV_DIVZERO_FLAG_EN
    assign divz = divz_q;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: scoreboard bench for mult_div_unit (WIDTH=32) with an arithmetic reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] rd1 = '0;
    logic [W-1:0] rd2 = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
`ifdef MULDIV_DIVZERO_FLAG_EN
    logic         divz;
`endif

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .rd1   (rd1),
        .rd2   (rd2),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
`ifdef MULDIV_DIVZERO_FLAG_EN
        .lo    (lo),
        .divz  (divz)
`else
        .lo    (lo)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];
    exp_t last_e;
    int   total = 0;
    int   bad = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: plain integer arithmetic plus the two architectural special cases.
    function automatic exp_t model(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (o)
            2'b00: begin
                p = 64'(sa * sb);
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == '0) begin
                    e.lo = '1;
                    e.hi = a;
                    e.dz = 1'b1;
                end else if (o == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = a;
                        e.hi = '0;
                    end else begin
                        q = sa / sb;
                        r = sa % sb;
                        e.lo = q[31:0];
                        e.hi = r[31:0];
                    end
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: every done pulse must match the oldest pending expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result (hi=%0h lo=%0h)", hi, lo);
                end else begin
                    e = sb_q.pop_front();
                    check("result_hi", hi, e.hi);
                    check("result_lo", lo, e.lo);
`ifdef MULDIV_DIVZERO_FLAG_EN
                    check("result_divz", divz, e.dz);
`endif
                end
            end
        end
    end

    // Waits for idle, drives start for one edge, returns at the negedge after the start edge.
    task automatic issue(logic [1:0] o, logic [W-1:0] a, logic [W-1:0] b, bit expect_it);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_before_start", busy, 0);
        op    = o;
        rd1   = a;
        rd2   = b;
        start = 1'b1;
        if (expect_it) begin
            last_e = model(o, a, b);
            sb_q.push_back(last_e);
        end
        @(negedge clk);
        start = 1'b0;
        op    = 2'($urandom);
        rd1   = $urandom;
        rd2   = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", sb_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_state", {busy, done, hi, lo}, 0);

        // MULTU all-ones: exact latency and busy window.
        op    = 2'b01;
        rd1   = 32'hFFFF_FFFF;
        rd2   = 32'hFFFF_FFFF;
        start = 1'b1;
        last_e = model(2'b01, rd1, rd2);
        sb_q.push_back(last_e);
        @(negedge clk);
        start = 1'b0;
        rd1   = 32'h1234_5678;
        rd2   = 32'h0;
        for (int k = 0; k <= 32; k++) begin
            check($sformatf("busy_window_e%0d", k), {busy, done}, 2'b10);
            @(negedge clk);
        end
        check("done_after_e33", {busy, done}, 2'b01);
        check("multu_ones_hi", hi, 32'hFFFF_FFFE);
        check("multu_ones_lo", lo, 32'h0000_0001);
        @(negedge clk);
        check("done_falls_e34", done, 0);

        issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1);
        issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1);
        issue(2'b11, 32'd100, 32'd7, 1'b1);
        drain();
        repeat (4) @(negedge clk);
        check("hold_hi", hi, last_e.hi);
        check("hold_lo", lo, last_e.lo);

        issue(2'b11, 32'h64, 32'h0, 1'b1);
        drain();
        check("divzero_lo", lo, 32'hFFFF_FFFF);
        check("divzero_hi", hi, 32'h0000_0064);
`ifdef MULDIV_DIVZERO_FLAG_EN
        repeat (3) @(negedge clk);
        check("divz_sticky", divz, 1);
`endif
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
`ifdef MULDIV_DIVZERO_FLAG_EN
        check("divz_cleared_on_start", divz, 0);
`endif
        drain();
        check("ovf_lo", lo, 32'h8000_0000);
        check("ovf_hi", hi, 32'h0);

        // Start pulse while busy (edge 10) must be ignored.
        issue(2'b01, 32'd5, 32'd6, 1'b1);
        repeat (9) @(negedge clk);
        op    = 2'b11;
        rd1   = 32'd99;
        rd2   = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("ignored_start_idle", busy, 0);
        check("ignored_start_lo", lo, 32'h1E);
        check("ignored_start_hi", hi, 32'h0);

        // Reset in flight: no result, no done pulse afterwards.
        issue(2'b01, 32'd2, 32'd3, 1'b0);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_hi", hi, 0);
        check("midreset_lo", lo, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        check("after_reset_idle", {busy, hi, lo}, 0);

        for (int i = 0; i < 40; i++) begin
            issue(2'($urandom), pick(), pick(), 1'b1);
        end
        drain();

        check("scoreboard_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
